// File: rtl/div_iter_32.sv
// Iterative restoring divider for DIV/DIVU. It produces one quotient bit per cycle and has a fixed latency.
// Optional signed support is enabled by defining DIV_ITER_SIGNED_EN. Without it, every division is unsigned.
module div_iter_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] dvs;
    logic             zero_dvs;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    // The dividend shifts out of the top of work as quotient bits shift in at the bottom.
    assign shifted = {rem, work[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs};
    assign fits    = ~diff[WIDTH+1];

`ifdef DIV_ITER_SIGNED_EN
    logic dvd_neg;
    logic dvs_neg;
    logic neg_q;
    logic neg_r;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
    assign q_res   = neg_q ? -work : work;
    assign r_res   = neg_r ? -rem : rem;
`else
    logic unused_sign;

    assign unused_sign = is_signed;
    assign dvd_mag     = dividend;
    assign dvs_mag     = divisor;
    assign q_res       = work;
    assign r_res       = rem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            work      <= '0;
            dvs       <= '0;
            zero_dvs  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV_ITER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem      <= '0;
                        work     <= dvd_mag;
                        dvs      <= dvs_mag;
                        zero_dvs <= (divisor == '0);
                        count    <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= CALC;
`ifdef DIV_ITER_SIGNED_EN
                        neg_q    <= dvd_neg ^ dvs_neg;
                        neg_r    <= dvd_neg;
`endif
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        rem   <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        work  <= {work[WIDTH-2:0], fits};
                        count <= count - 1'b1;
                    end else begin
                        // A zero divisor leaves all-ones in work and the dividend in rem, so only the quotient is forced.
                        quotient  <= zero_dvs ? '1 : q_res;
                        remainder <= r_res;
                        div_zero  <= zero_dvs;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_32.sv
// Self-checking bench for div_iter_32. A cycle-level behavioural model is compared against the DUT every cycle.
// The bench also runs directed cases with literal expectations and a randomized start/operand stream.
module tb_div_iter_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int compared;
    int mismatched;

    div_iter_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic; SV division on longint truncates toward zero like C.
    function automatic void model_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
`ifdef DIV_ITER_SIGNED_EN
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                qq = sa / sb;
                rr = sa % sb;
                q  = qq[31:0];
                r  = rr[31:0];
            end
`else
            sa = longint'(s);
            sb = sa;
            qq = sb;
            rr = qq;
`endif
        end
    endfunction

    int          edge_cnt;
    int          accept_edge;
    logic [31:0] pend_q, pend_r, exp_q, exp_r;
    logic        pend_z, exp_z;

    // Model timeline: accept at edge E, busy through edge E+32, done after edge E+33, idle again at E+34.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt    = 0;
            accept_edge = -1;
            exp_q       = '0;
            exp_r       = '0;
            exp_z       = 1'b0;
        end else begin
            edge_cnt++;
            if (accept_edge < 0) begin
                if (start) begin
                    accept_edge = edge_cnt;
                    model_div(is_signed, dividend, divisor, pend_q, pend_r, pend_z);
                end
            end else if (edge_cnt == accept_edge + 33) begin
                exp_q = pend_q;
                exp_r = pend_r;
                exp_z = pend_z;
            end else if (edge_cnt == accept_edge + 34) begin
                accept_edge = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("busy", {31'd0, busy},
                         {31'd0, (accept_edge >= 0) && (edge_cnt <= accept_edge + 32)});
            check_output("done", {31'd0, done},
                         {31'd0, (accept_edge >= 0) && (edge_cnt == accept_edge + 33)});
            check_output("quotient", quotient, exp_q);
            check_output("remainder", remainder, exp_r);
            check_output("div_zero", {31'd0, div_zero}, {31'd0, exp_z});
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input int inject_at, output logic [31:0] q, output logic [31:0] r,
                                  output logic z, output int lat);
        logic got;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        got = 1'b0;
        lat = 0;
        q = '0;
        r = '0;
        z = 1'b0;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(posedge clk);
            lat = n;
            @(negedge clk);
            start = 1'b0;
            if (n == inject_at) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            if (done) begin
                got = 1'b1;
                q = quotient;
                r = remainder;
                z = div_zero;
            end
        end
        start = 1'b0;
        check_output("done_seen", {31'd0, got}, 32'd1);
    endtask

    logic [31:0] q, r;
    logic        z;
    int          lat;
    int          extra_done;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        is_signed  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_q", quotient, 32'd0);
        check_output("reset_r", remainder, 32'd0);
        check_output("reset_z", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        // 100/7 with a spurious start sampled at edge 10 that must be ignored.
        apply_stimulus(32'd100, 32'd7, 1'b0, 9, q, r, z, lat);
        check_output("div100_7_q", q, 32'd14);
        check_output("div100_7_r", r, 32'd2);
        check_output("div100_7_z", {31'd0, z}, 32'd0);
        check_output("div100_7_latency", lat, 32'd33);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check_output("no_second_done", extra_done, 32'd0);

        apply_stimulus(32'h0000_1234, 32'd0, 1'b0, 0, q, r, z, lat);
        check_output("divzero_q", q, 32'hFFFF_FFFF);
        check_output("divzero_r", r, 32'h0000_1234);
        check_output("divzero_z", {31'd0, z}, 32'd1);
        check_output("divzero_latency", lat, 32'd33);

        apply_stimulus(32'd9, 32'd3, 1'b0, 0, q, r, z, lat);
        check_output("div9_3_q", q, 32'd3);
        check_output("div9_3_r", r, 32'd0);
        check_output("div9_3_z", {31'd0, z}, 32'd0);

        apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0, q, r, z, lat);
`ifdef DIV_ITER_SIGNED_EN
        check_output("sdiv_m7_2_q", q, 32'hFFFF_FFFD);
        check_output("sdiv_m7_2_r", r, 32'hFFFF_FFFF);
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, q, r, z, lat);
        check_output("sdiv_ovf_q", q, 32'h8000_0000);
        check_output("sdiv_ovf_r", r, 32'd0);
        check_output("sdiv_ovf_z", {31'd0, z}, 32'd0);
`else
        check_output("sdiv_m7_2_q", q, 32'h7FFF_FFFC);
        check_output("sdiv_m7_2_r", r, 32'd1);
`endif

        // An asynchronous reset in the middle of CALC must clear the outputs without waiting for a clock.
        apply_stimulus(32'd100, 32'd7, 1'b0, 0, q, r, z, lat);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_busy", {31'd0, busy}, 32'd0);
        check_output("midreset_done", {31'd0, done}, 32'd0);
        check_output("midreset_q", quotient, 32'd0);
        check_output("midreset_r", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0, q, r, z, lat);
        check_output("after_reset_q", q, 32'hFFFF_FFFF);
        check_output("after_reset_r", r, 32'd0);
        check_output("after_reset_latency", lat, 32'd33);

        // Random stream: start pulses arrive at any time and are accepted only when the divider is idle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            is_signed = $urandom_range(0, 1) == 1;
            dividend  = $urandom;
            case ($urandom_range(0, 7))
                0:       divisor = 32'd0;
                1, 2:    divisor = $urandom_range(1, 15);
                3:       divisor = 32'hFFFF_FFFF - $urandom_range(0, 3);
                4: begin
                    dividend = 32'h8000_0000;
                    divisor  = 32'hFFFF_FFFF;
                end
                default: divisor = $urandom;
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
